pixel_scheduler: RTL and testbench

Downstream consumer of the instruction processor. Waits until scene memory reports ready and no scene-update instruction is in flight, then snapshots the current camera and light. It then raster-scans every pixel of the frame, handing (x, y) coordinates plus the frozen camera/light to the ray-generation stage over a valid/ready handshake. The snapshot means later scene instructions cannot tear a frame that is being rendered.

---
 rtl/pixel_scheduler.sv | 173 +++++++++++++++++
 tb/tb_pixel_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scheduler.sv
// pixel_scheduler: waits for a quiet, loaded scene, snapshots camera/light,
// then raster-scans WIDTH x HEIGHT pixel coordinates to the ray generator.
//
// Handshake (pix_*): a transfer happens on a rising edge where
// pix_valid && pix_ready. While pix_valid is high and pix_ready is low,
// pix_x, pix_y, pix_last, frame_camera and frame_light hold stable, and
// pix_valid only drops after a transfer, on abort, or on reset.

package pixel_scheduler_pkg;
  typedef struct packed {
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] pos_z;
    logic [15:0] yaw;
  } Camera;

  typedef struct packed {
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] pos_z;
    logic [15:0] intensity;
  } Light;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_SCAN     = 2'd2,
    S_DONE     = 2'd3
  } state_t;
endpackage

module pixel_scheduler
  import pixel_scheduler_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  parameter int FCW    = 16
) (
  input  logic           clk_100mhz,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           mem_ready,
  input  logic           execInst_valid,
  input  Camera          cur_camera,
  input  Light           cur_light,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic [XW-1:0]  pix_x,
  output logic [YW-1:0]  pix_y,
  output logic           pix_last,
  output Camera          frame_camera,
  output Light           frame_light,
  output logic           busy,
  output logic           frame_done,
  output logic [FCW-1:0] frame_count,
  output logic [1:0]     dbg_state
);

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_pix_valid;
  logic [XW-1:0]    r_pix_x;
  logic [YW-1:0]    r_pix_y;
  Camera            r_frame_camera;
  Light             r_frame_light;
  logic [FCW-1:0]   r_frame_count;

  logic             w_xfer;
  logic             w_row_end;
  logic             w_frame_end;
  logic             w_scene_quiet;

  assign w_xfer        = r_pix_valid && pix_ready;
  assign w_row_end     = (r_pix_x == X_MAX);
  assign w_frame_end   = w_row_end && (r_pix_y == Y_MAX);
  assign w_scene_quiet = mem_ready && !execInst_valid;

  // State register; reset drops any frame in flight.
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort wins over a simultaneous transfer or start.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_next_state = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        if (abort)              w_next_state = S_IDLE;
        else if (w_scene_quiet) w_next_state = S_SCAN;
      end
      S_SCAN: begin
        if (abort)                        w_next_state = S_IDLE;
        else if (w_xfer && w_frame_end)   w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: snapshot on scan entry, raster advance on transfer, frame counter.
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      r_pix_valid    <= 1'b0;
      r_pix_x        <= '0;
      r_pix_y        <= '0;
      r_frame_camera <= '0;
      r_frame_light  <= '0;
      r_frame_count  <= '0;
    end else begin
      case (r_state)
        S_WAIT_MEM: begin
          if (!abort && w_scene_quiet) begin
            r_frame_camera <= cur_camera;
            r_frame_light  <= cur_light;
            r_pix_x        <= '0;
            r_pix_y        <= '0;
            r_pix_valid    <= 1'b1;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_pix_valid <= 1'b0;
          end else if (w_xfer) begin
            if (w_frame_end) begin
              // Coordinates park on the final pixel.
              r_pix_valid <= 1'b0;
            end else if (w_row_end) begin
              r_pix_x <= '0;
              r_pix_y <= r_pix_y + YW'(1);
            end else begin
              r_pix_x <= r_pix_x + XW'(1);
            end
          end
        end
        S_DONE: begin
          r_frame_count <= r_frame_count + FCW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    busy         = (r_state != S_IDLE);
    frame_done   = (r_state == S_DONE);
    pix_valid    = r_pix_valid;
    pix_x        = r_pix_x;
    pix_y        = r_pix_y;
    pix_last     = r_pix_valid && w_frame_end;
    frame_camera = r_frame_camera;
    frame_light  = r_frame_light;
    frame_count  = r_frame_count;
    dbg_state    = r_state;
  end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Bench for pixel_scheduler at WIDTH=4, HEIGHT=3, FCW=4.
module tb_pixel_scheduler;
  import pixel_scheduler_pkg::*;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int XW     = 2;
  localparam int YW     = 2;
  localparam int FCW    = 4;
  localparam int W      = XW + YW + 1 + 64 + 64;
  localparam int LAST_BIT = 128;

  localparam Camera CAM_A = 64'h0001_0002_0003_0004;
  localparam Light  LIT_A = 64'h0011_0012_0013_0014;
  localparam Camera CAM_B = 64'h00B1_00B2_00B3_00B4;
  localparam Light  LIT_B = 64'h01B1_01B2_01B3_01B4;
  localparam Camera CAM_C = 64'hC001_C002_C003_C004;
  localparam Light  LIT_C = 64'hCC01_CC02_CC03_CC04;
  localparam Camera CAM_D = 64'hDEAD_BEEF_1234_5678;

  logic           clk_100mhz = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           mem_ready = 1'b0;
  logic           execInst_valid = 1'b0;
  Camera          cur_camera = '0;
  Light           cur_light = '0;
  logic           pix_valid;
  logic           pix_ready = 1'b1;
  logic [XW-1:0]  pix_x;
  logic [YW-1:0]  pix_y;
  logic           pix_last;
  Camera          frame_camera;
  Light           frame_light;
  logic           busy;
  logic           frame_done;
  logic [FCW-1:0] frame_count;
  logic [1:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int xfer_cnt = 0;
  int done_cnt = 0;
  int exp_fc = 0;
  bit exp_done = 1'b0;
  bit rand_mode = 1'b0;
  bit stall_chk = 1'b0;
  logic [W:0] stall_prev;
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;

  pixel_scheduler #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FCW(FCW)) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .start(start), .abort(abort),
    .mem_ready(mem_ready), .execInst_valid(execInst_valid),
    .cur_camera(cur_camera), .cur_light(cur_light),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
    .frame_camera(frame_camera), .frame_light(frame_light),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_100mhz = ~clk_100mhz;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_100mhz) begin
    if (rst) begin
      if (frame_done || exp_done) begin
        checks++;
        if (frame_done !== exp_done) begin
          errors++;
          $display("FAIL frame_done act=%0b exp=%0b", frame_done, exp_done);
        end
      end
      if (exp_done) begin
        done_cnt++;
        exp_fc = (exp_fc + 1) % 16;
      end
      exp_done = 1'b0;
      mon_act = {pix_x, pix_y, pix_last, frame_camera, frame_light};
      if (stall_chk) begin
        checks++;
        if ({pix_valid, mon_act} !== stall_prev) begin
          errors++;
          $display("FAIL stall_hold act=%h exp=%h", {pix_valid, mon_act}, stall_prev);
        end
      end
      stall_chk  = pix_valid && !pix_ready && !abort;
      stall_prev = {1'b1, mon_act};
      if (pix_valid && pix_ready && !abort) begin
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel act=%h", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL pixel act=%h exp=%h", mon_act, mon_exp);
          end
          exp_done = mon_exp[LAST_BIT];
        end
      end
    end else begin
      exp_done  = 1'b0;
      stall_chk = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
    if (rand_mode) pix_ready = ($urandom_range(0, 99) < 30);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
    exp_fc = 0;
  endtask

  task automatic push_frame(input Camera c, input Light l);
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++)
        exp_q.push_back({XW'(x), YW'(y), (x == WIDTH-1 && y == HEIGHT-1), c, l});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (xfer_cnt < n && k < budget) begin
      tick();
      k++;
    end
    if (xfer_cnt < n) begin
      errors++;
      $display("FAIL wait_xfers act=%0d exp=%0d", xfer_cnt, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    if (busy) begin
      errors++;
      $display("FAIL wait_idle act=busy exp=idle");
    end
  endtask

  task automatic run_frame(input Camera c, input Light l);
    int base;
    base = xfer_cnt;
    cur_camera = c;
    cur_light  = l;
    mem_ready  = 1'b1;
    execInst_valid = 1'b0;
    pix_ready  = 1'b1;
    push_frame(c, l);
    pulse_start();
    wait_xfers(base + 12, 60);
    wait_idle(10);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int done0;

    // Reset and idle outputs
    do_reset(3);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_xy", {pix_x, pix_y}, 0);
    check("rst_pix_last", pix_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_frame_camera", frame_camera, 0);
    check("rst_frame_light", frame_light, 0);
    check("rst_state", dbg_state, 0);

    // Full frame with pix_ready=1 and start latency
    cur_camera = CAM_A;
    cur_light  = LIT_A;
    mem_ready  = 1'b1;
    pix_ready  = 1'b1;
    push_frame(CAM_A, LIT_A);
    pulse_start();
    check("lat_busy", busy, 1);
    check("lat_valid_early", pix_valid, 0);
    tick();
    check("lat_valid", pix_valid, 1);
    check("lat_xy", {pix_x, pix_y}, 0);
    wait_xfers(12, 40);
    wait_idle(10);
    check("f1_done_cnt", done_cnt, 1);
    check("f1_frame_count", frame_count, 1);
    check("f1_q_empty", exp_q.size(), 0);

    // Abort together with start in IDLE drops the start
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("idle_abort_busy", busy, 0);

    // Backpressure: pix_ready high ~30% of cycles
    base = xfer_cnt;
    cur_camera = CAM_B;
    cur_light  = LIT_B;
    push_frame(CAM_B, LIT_B);
    rand_mode = 1'b1;
    pulse_start();
    wait_xfers(base + 12, 400);
    rand_mode = 1'b0;
    pix_ready = 1'b1;
    wait_idle(10);
    check("bp_frame_count", frame_count, 2);
    check("bp_q_empty", exp_q.size(), 0);

    // Gated start and snapshot
    base = xfer_cnt;
    mem_ready = 1'b0;
    pulse_start();
    repeat (5) tick();
    check("gate_mem_valid", pix_valid, 0);
    check("gate_mem_busy", busy, 1);
    mem_ready = 1'b1;
    execInst_valid = 1'b1;
    repeat (2) tick();
    check("gate_exec_valid", pix_valid, 0);
    cur_camera = CAM_C;
    cur_light  = LIT_C;
    execInst_valid = 1'b0;
    push_frame(CAM_C, LIT_C);
    tick();
    check("gate_open_valid", pix_valid, 1);
    check("gate_snap_camera", frame_camera, CAM_C);
    wait_xfers(base + 3, 20);
    cur_camera = CAM_D;
    mem_ready = 1'b0;
    execInst_valid = 1'b1;
    wait_xfers(base + 12, 40);
    wait_idle(10);
    check("gate_hold_camera", frame_camera, CAM_C);
    check("gate_frame_count", frame_count, exp_fc);

    // Abort at the 5th transfer edge
    base  = xfer_cnt;
    done0 = done_cnt;
    push_frame(CAM_A, LIT_A);
    cur_camera = CAM_A;
    cur_light  = LIT_A;
    mem_ready = 1'b1;
    execInst_valid = 1'b0;
    pix_ready = 1'b1;
    pulse_start();
    wait_xfers(base + 4, 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", pix_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, 0);
    check("abort_remaining", exp_q.size(), 8);
    exp_q.delete();
    repeat (3) tick();
    check("abort_no_done", done_cnt, done0);
    check("abort_frame_count", frame_count, 3);
    run_frame(CAM_B, LIT_A);
    check("restart_frame_count", frame_count, 4);

    // Counter wrap
    for (int i = 0; i < 11; i++) run_frame(CAM_C, LIT_B);
    check("wrap_pre", frame_count, 15);
    run_frame(CAM_A, LIT_C);
    check("wrap_post", frame_count, 0);
    check("wrap_model", frame_count, exp_fc);

    // Reset mid-frame
    base  = xfer_cnt;
    done0 = done_cnt;
    push_frame(CAM_B, LIT_B);
    cur_camera = CAM_B;
    cur_light  = LIT_B;
    pulse_start();
    wait_xfers(base + 3, 20);
    rst = 1'b0;
    tick();
    check("mrst_valid", pix_valid, 0);
    check("mrst_xy", {pix_x, pix_y}, 0);
    check("mrst_busy", busy, 0);
    check("mrst_frame_done", frame_done, 0);
    check("mrst_camera", frame_camera, 0);
    check("mrst_light", frame_light, 0);
    rst = 1'b1;
    exp_fc = 0;
    check("mrst_remaining", exp_q.size(), 9);
    exp_q.delete();
    repeat (4) tick();
    check("mrst_no_done", done_cnt, done0);
    check("mrst_frame_count", frame_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
